inst_rom_ld: RTL and testbench
==============================

// Module: inst_rom_ld
// PURPOSE
//  Instruction-memory responder for the openmips fetch port: answers rom_ce/rom_addr with rom_data in the same cycle.
//  Adds a byte-serial load port that fills the array big-endian, so programs are downloaded at run time instead of $readmemh.
//  Sits beside openmips at SoC top; fetch side wires straight to rom_ce_o/rom_addr_o/rom_data_i.
// PARAMETERS
//  ADDR_W   10   word-address bits; depth = 2**ADDR_W 32-bit words
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  rom_ce_i   in   1   fetch enable from CPU
//  rom_addr_i in   32  byte address from CPU pc
//  rom_data_o out  32  instruction word (combinational read)
//  ld_start   in   1   pulse: begin a load session at word 0
//  ld_valid   in   1   ld_byte valid
//  ld_byte    in   8   load data byte, MSB-first within word
//  ld_last    in   1   qualifies final byte of session
//  ld_ready   out  1   block accepts ld_byte this cycle
//  ld_busy    out  1   load session in progress
//  ld_done    out  1   one-cycle pulse at session end
//  ld_err     out  1   sticky: write beyond depth attempted
//  ld_words   out  ADDR_W+1  words written in current/last session
//  ld_csum    out  32  checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; ld_ready/ld_busy/ld_done/ld_err=0; ld_words=0; ld_csum=0; byte cnt=0; array contents NOT cleared.
//  Fetch: rom_data_o = mem[rom_addr_i[ADDR_W+1:2]] when rom_ce_i=1, state IDLE, rom_addr_i[31:ADDR_W+2]==0; else 32'h0 (nop).
//   rom_addr_i[1:0] ignored. Zero-latency combinational read; word written at edge N visible to fetch after edge N.
//  FSM IDLE -> LOAD on ld_start (clears ld_words, ld_err, ld_csum, byte cnt, word ptr).
//   LOAD: ld_ready=1, ld_busy=1; byte accepted iff ld_valid&&ld_ready.
//   Byte k (0..3) of word lands in bits [31-8k -: 8]; on 4th byte word written to mem[ptr], ptr++, ld_words++.
//   Accepted byte with ld_last: partial word zero-padded in low bytes and written same edge; 0 bytes pending -> nothing extra written.
//   LOAD -> DONE after accepted ld_last byte; DONE lasts 1 cycle: ld_done=1, ld_ready=0, ld_busy=1; DONE -> IDLE.
//  Overflow: word completing with ptr==2**ADDR_W is discarded, ld_err set, ld_words saturates at 2**ADDR_W; session continues to ld_last.
//  ld_start while LOAD/DONE: ignored. ld_valid in IDLE/DONE: ignored, no state change.
//  ld_start and ld_valid same cycle in IDLE: byte ignored (ld_ready still 0 that cycle).
//  rst mid-session: back to IDLE at once, partial word dropped, words already written stay.
//  Fetch during LOAD/DONE returns 32'h0 so CPU executes sll $0 nops; no stall handshake to CPU.
// CONFIGURATION
//  INST_ROM_LD_CSUM_EN defined: ld_csum = mod-2**32 sum of every word actually written (incl. padded last word, excl. discarded),
//   updated on the write edge, cleared by ld_start and rst.
//  Undefined: no adder/register; ld_csum tied to 32'h0.
// TESTING
//  1) rst, ld_start, bytes 34 02 00 01 (last on 4th) -> mem[0]=32'h34020001, ld_done 1 cycle, ld_words=1; fetch addr 0 -> 32'h34020001.
//  2) 6 bytes AA BB CC DD 11 22, last on 6th -> mem[0]=32'hAABBCCDD, mem[1]=32'h11220000, ld_words=2; csum(EN)=32'hBBDDCCDD.
//  3) ld_valid toggling 1/0 each cycle -> identical result to 1); ld_ready low in IDLE and DONE; ld_start during LOAD ignored.
//  4) ADDR_W=2, load 5 words -> mem[0..3] correct, ld_err=1, ld_words=4; csum excludes 5th; ld_start clears ld_err.
//  5) fetch during LOAD -> 0; addr 32'h0000_1000 with ADDR_W=10 -> 0; rom_ce_i=0 -> 0; rom_addr_i=32'h6 reads mem[1].
//  6) rst after 2 bytes of word 3 -> IDLE, ld_busy=0, words 0..2 intact and fetchable, word 3 unchanged.

Source files
------------

// File: rtl/inst_rom_ld.sv
// -----------------------------------------------------------------------------
// inst_rom_ld
//   Instruction memory for the openmips fetch port. It has a byte-serial load
//   port, so a program can be downloaded at run time instead of being
//   preloaded at build time.
//
//   Fetch side:
//     - rom_data_o is a zero-latency combinational read of the word addressed
//       by rom_addr_i.
//     - It returns 32'h0 (a nop) when rom_ce_i is low, when the address is
//       beyond the array depth, or while a load session is active.
//
//   Load side:
//     - ld_start opens a session that fills the array from word 0.
//     - Bytes arrive big-endian: the first byte of a word lands in [31:24].
//     - ld_last closes the session. A partial last word is zero-padded.
//
//   Optional feature:
//     - Define INST_ROM_LD_CSUM_EN to build the running checksum of every
//       word written.
//     - Without it, ld_csum is tied to zero.
//
// Ports
//   clk, rst               single clock, synchronous active-high reset
//   rom_ce_i, rom_addr_i   fetch enable / byte address from CPU
//   rom_data_o             instruction word
//   ld_start               pulse: begin a load session at word 0
//   ld_valid/ld_byte       load byte strobe and data
//   ld_last                final byte of the session
//   ld_ready               byte accepted this cycle when ld_valid is high
//   ld_busy                session in progress (LOAD or DONE)
//   ld_done                one-cycle end-of-session pulse
//   ld_err                 sticky: write beyond the array depth attempted
//   ld_words               words written in the current/last session
//   ld_csum                mod-2^32 sum of the words written
// -----------------------------------------------------------------------------
module inst_rom_ld #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W:0]   ld_words,
  output logic [31:0]       ld_csum
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;

  logic [31:0]     r_mem [DEPTH];

  // The word pointer is one bit wider than the array index. Its MSB set
  // means the array is full.
  logic [ADDR_W:0] r_ptr;
  logic [1:0]      r_bcnt;
  logic [23:0]     r_acc;
  logic            r_err;

  logic            w_accept;
  logic            w_wr_word;
  logic            w_room;
  logic            w_mem_we;
  logic            w_start;
  logic            w_in_range;
  logic [31:0]     w_word;
  logic            w_unused_addr_lsb;

  // ---------------------------------------------------------------------------
  // FSM: next state and session status outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ld_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (ld_valid && ld_last) w_next = S_DONE;
      end
      S_DONE: begin
        ld_busy = 1'b1;
        ld_done = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------------
  assign w_start   = (r_state == S_IDLE) && ld_start;
  assign w_accept  = ld_valid && ld_ready;
  assign w_wr_word = w_accept && ((r_bcnt == 2'd3) || ld_last);
  assign w_room    = ~r_ptr[ADDR_W];
  assign w_mem_we  = w_wr_word && w_room && !rst;

  // The new byte is merged with the bytes already held. Lower byte lanes
  // stay zero, which gives the padding for a short last word. The same
  // value feeds both the accumulator and the memory write.
  always_comb begin
    w_word = 32'h0;
    case (r_bcnt)
      2'd0: w_word = {ld_byte, 24'h0};
      2'd1: w_word = {r_acc[23:16], ld_byte, 16'h0};
      2'd2: w_word = {r_acc[23:8], ld_byte, 8'h0};
      2'd3: w_word = {r_acc, ld_byte};
      default: w_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_bcnt <= '0;
      r_acc  <= '0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_ptr  <= '0;
      r_bcnt <= '0;
      r_acc  <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      if (w_wr_word) begin
        r_bcnt <= '0;
        r_acc  <= '0;
        // A full array drops the word. The pointer then saturates, so it
        // also serves as the word count.
        if (w_room) r_ptr <= r_ptr + 1'b1;
        else        r_err <= 1'b1;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
        r_acc  <= w_word[31:8];
      end
    end
  end

  assign ld_err   = r_err;
  assign ld_words = r_ptr;

  // The array has no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_ptr[ADDR_W-1:0]] <= w_word;
  end

  // ---------------------------------------------------------------------------
  // Checksum
  // ---------------------------------------------------------------------------
`ifdef INST_ROM_LD_CSUM_EN
  logic [31:0] r_csum;

  always_ff @(posedge clk) begin
    if (rst || w_start) r_csum <= '0;
    else if (w_mem_we)  r_csum <= r_csum + w_word;
  end

  assign ld_csum = r_csum;
`else
  assign ld_csum = 32'h0;
`endif

  // ---------------------------------------------------------------------------
  // Fetch port
  // ---------------------------------------------------------------------------
  // The CPU always fetches aligned words, so the byte offset bits carry no
  // information.
  assign w_unused_addr_lsb = ^rom_addr_i[1:0];
  assign w_in_range        = (rom_addr_i[31:ADDR_W+2] == '0);

  // Nops are served while loading. The CPU has no stall path, so it spins
  // harmlessly until the program is in place.
  assign rom_data_o = (rom_ce_i && (r_state == S_IDLE) && w_in_range) ?
                      r_mem[rom_addr_i[ADDR_W+1:2]] : 32'h0;

endmodule

// File: tb/tb_inst_rom_ld.sv
module tb_inst_rom_ld;

`ifdef INST_ROM_LD_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_ce_i = 1'b0;
  logic [31:0] rom_addr_i = 32'h0;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_last = 1'b0;

  // d0: deep array (ADDR_W=10), d1: tiny array (ADDR_W=2) to hit overflow
  logic [31:0] d0_data, d1_data, d0_csum, d1_csum;
  logic        d0_ready, d0_busy, d0_done, d0_err;
  logic        d1_ready, d1_busy, d1_done, d1_err;
  logic [10:0] d0_words;
  logic [2:0]  d1_words;

  inst_rom_ld #(.ADDR_W(10)) u_big (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .rom_data_o(d0_data), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(d0_ready),
    .ld_busy(d0_busy), .ld_done(d0_done), .ld_err(d0_err),
    .ld_words(d0_words), .ld_csum(d0_csum));

  inst_rom_ld #(.ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .rom_data_o(d1_data), .ld_start(ld_start), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(d1_ready),
    .ld_busy(d1_busy), .ld_done(d1_done), .ld_err(d1_err),
    .ld_words(d1_words), .ld_csum(d1_csum));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: expected memory images and session status
  logic [7:0]  sess_q[$];
  logic [31:0] m0 [int];
  logic [31:0] m1 [int];
  int          ew0, ew1;
  bit          ee0, ee1;
  logic [31:0] ec0, ec1;

  // Pack the session bytes into big-endian words (zero padded), clip at depth
  task automatic model_apply(input int nsent, input bit complete);
    int nw;
    logic [31:0] w;
    nw = complete ? (nsent + 3) / 4 : nsent / 4;
    ew0 = 0; ew1 = 0; ee0 = 0; ee1 = 0; ec0 = 0; ec1 = 0;
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (i*4 + j < nsent) w[31-8*j -: 8] = sess_q[i*4 + j];
      if (i < 1024) begin m0[i] = w; ew0++; ec0 += w; end else ee0 = 1;
      if (i < 4)    begin m1[i] = w; ew1++; ec1 += w; end else ee1 = 1;
    end
    if (!complete) begin
      ew0 = 0; ew1 = 0; ee0 = 0; ee1 = 0; ec0 = 0; ec1 = 0;
    end
  endtask

  // Drive one session; gap 0=none 1=alternate 2=random; dirty adds ignored
  // ld_valid/ld_start noise; abort_at>=0 hits rst before that byte.
  task automatic run_session(input string nm, input int gap, input bit dirty,
                             input int abort_at);
    int n;
    int g;
    n = sess_q.size();
    ld_start = 1'b1; ld_valid = dirty; ld_byte = 8'($urandom); ld_last = dirty;
    rom_ce_i = 1'b1; rom_addr_i = {26'h0, 4'($urandom), 2'b00};
    #1;
    checks++;
    if (d0_ready !== 1'b0 || d1_ready !== 1'b0) begin
      errors++; $display("FAIL %s ready_in_idle got %b/%b exp 0", nm, d0_ready, d1_ready);
    end
    @(posedge clk); #1;
    ld_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        ld_valid = 1'b0; ld_byte = 8'($urandom); ld_last = 1'($urandom);
        ld_start = 1'($urandom);
        #1;
        checks++;
        if (d0_busy !== 1'b1 || d1_busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_gap got %b/%b exp 1", nm, d0_busy, d1_busy);
        end
        @(posedge clk); #1;
      end
      ld_start = 1'b0;
      if (k == abort_at) begin
        ld_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      ld_valid = 1'b1; ld_byte = sess_q[k]; ld_last = (k == n - 1);
      #1;
      checks++;
      if (d0_ready !== 1'b1 || d1_ready !== 1'b1) begin
        errors++; $display("FAIL %s ready_load got %b/%b exp 1", nm, d0_ready, d1_ready);
      end
      checks++;
      if (d0_data !== 32'h0 || d1_data !== 32'h0) begin
        errors++; $display("FAIL %s fetch_in_load got %h/%h exp 0", nm, d0_data, d1_data);
      end
      @(posedge clk); #1;
    end
    ld_valid = dirty; ld_byte = 8'($urandom); ld_last = 1'b0; ld_start = dirty;
    #1;
    checks++;
    if (d0_done !== 1'b1 || d1_done !== 1'b1 || d0_ready !== 1'b0 || d0_busy !== 1'b1) begin
      errors++; $display("FAIL %s done_state got done=%b/%b ready=%b busy=%b exp 1/1/0/1",
                         nm, d0_done, d1_done, d0_ready, d0_busy);
    end
    checks++;
    if (d0_data !== 32'h0) begin
      errors++; $display("FAIL %s fetch_in_done got %h exp 0", nm, d0_data);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_start = 1'b0; rom_ce_i = 1'b0;
    #1;
    checks++;
    if (d0_done !== 1'b0 || d1_done !== 1'b0 || d0_busy !== 1'b0 || d1_busy !== 1'b0) begin
      errors++; $display("FAIL %s back_to_idle got done=%b/%b busy=%b/%b exp 0",
                         nm, d0_done, d1_done, d0_busy, d1_busy);
    end
  endtask

  task automatic check_status(input string nm);
    checks++;
    if (d0_words !== 11'(ew0) || d1_words !== 3'(ew1)) begin
      errors++; $display("FAIL %s words got %0d/%0d exp %0d/%0d", nm, d0_words, d1_words, ew0, ew1);
    end
    checks++;
    if (d0_err !== ee0 || d1_err !== ee1) begin
      errors++; $display("FAIL %s err got %b/%b exp %b/%b", nm, d0_err, d1_err, ee0, ee1);
    end
    checks++;
    if (d0_csum !== (CSUM_EN ? ec0 : 32'h0) || d1_csum !== (CSUM_EN ? ec1 : 32'h0)) begin
      errors++; $display("FAIL %s csum got %h/%h exp %h/%h", nm, d0_csum, d1_csum,
                         CSUM_EN ? ec0 : 32'h0, CSUM_EN ? ec1 : 32'h0);
    end
  endtask

  // Fetch every word the model knows; byte offset bits are randomized
  task automatic check_fetch(input string nm);
    logic [31:0] e1;
    foreach (m0[i]) begin
      rom_ce_i = 1'b1;
      rom_addr_i = 32'(i * 4 + int'($urandom_range(0, 3)));
      #1;
      checks++;
      if (d0_data !== m0[i]) begin
        errors++; $display("FAIL %s fetch0[%0d] got %h exp %h", nm, i, d0_data, m0[i]);
      end
      if (i >= 4 || m1.exists(i)) begin
        e1 = (i >= 4) ? 32'h0 : m1[i];
        checks++;
        if (d1_data !== e1) begin
          errors++; $display("FAIL %s fetch1[%0d] got %h exp %h", nm, i, d1_data, e1);
        end
      end
    end
    rom_ce_i = 1'b0;
  endtask

  task automatic load_bytes(input logic [31:0] w0, input logic [31:0] w1, input int n);
    logic [63:0] v;
    v = {w0, w1};
    sess_q.delete();
    for (int k = 0; k < n; k++) sess_q.push_back(v[63-8*k -: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_valid = 1'b1; ld_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({d0_ready, d0_busy, d0_done, d0_err, d1_ready, d1_busy, d1_done, d1_err} !== 8'h0) begin
      errors++; $display("FAIL reset flags got %b%b%b%b exp 0000", d0_ready, d0_busy, d0_done, d0_err);
    end
    checks++;
    if (d0_words !== 11'h0 || d1_words !== 3'h0 || d0_csum !== 32'h0 || d0_data !== 32'h0) begin
      errors++; $display("FAIL reset counters got words=%0d csum=%h data=%h exp 0", d0_words, d0_csum, d0_data);
    end
    rst = 1'b0; ld_valid = 1'b0; ld_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    load_bytes(32'h34020001, 32'h0, 4);
    run_session("basic", 0, 1'b0, -1);
    model_apply(4, 1'b1);
    check_status("basic");
    rom_ce_i = 1'b1; rom_addr_i = 32'h0;
    #1;
    checks++;
    if (d0_data !== 32'h34020001) begin
      errors++; $display("FAIL basic fetch0 got %h exp 34020001", d0_data);
    end
    rom_ce_i = 1'b0;
  endtask

  task automatic test_pad();
    load_bytes(32'hAABBCCDD, 32'h11220000, 6);
    run_session("pad", 0, 1'b0, -1);
    model_apply(6, 1'b1);
    check_status("pad");
    check_fetch("pad");
  endtask

  task automatic test_valid_toggle();
    load_bytes(32'h34020001, 32'h0, 4);
    run_session("toggle", 1, 1'b1, -1);
    model_apply(4, 1'b1);
    check_status("toggle");
    check_fetch("toggle");
  endtask

  task automatic test_overflow();
    sess_q.delete();
    for (int k = 0; k < 20; k++) sess_q.push_back(8'($urandom));
    run_session("overflow", 2, 1'b1, -1);
    model_apply(20, 1'b1);
    check_status("overflow");
    check_fetch("overflow");
    load_bytes(32'h01020304, 32'h0, 4);
    run_session("err_clear", 0, 1'b0, -1);
    model_apply(4, 1'b1);
    check_status("err_clear");
  endtask

  task automatic test_fetch();
    rom_ce_i = 1'b0; rom_addr_i = 32'h0;
    #1;
    checks++;
    if (d0_data !== 32'h0 || d1_data !== 32'h0) begin
      errors++; $display("FAIL fetch_ce0 got %h/%h exp 0", d0_data, d1_data);
    end
    rom_ce_i = 1'b1; rom_addr_i = 32'h0000_1000;
    #1;
    checks++;
    if (d0_data !== 32'h0 || d1_data !== 32'h0) begin
      errors++; $display("FAIL fetch_oor got %h/%h exp 0", d0_data, d1_data);
    end
    rom_addr_i = 32'h6;
    #1;
    checks++;
    if (d0_data !== m0[1] || d1_data !== m1[1]) begin
      errors++; $display("FAIL fetch_addr6 got %h/%h exp %h/%h", d0_data, d1_data, m0[1], m1[1]);
    end
    rom_ce_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    sess_q.delete();
    for (int k = 0; k < 16; k++) sess_q.push_back(8'($urandom));
    run_session("rst_mid", 2, 1'b0, 14);
    model_apply(14, 1'b0);
    #1;
    checks++;
    if (d0_busy !== 1'b0 || d1_busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid busy got %b/%b exp 0", d0_busy, d1_busy);
    end
    check_status("rst_mid");
    check_fetch("rst_mid");
  endtask

  task automatic test_random();
    int n;
    for (int s = 0; s < 6; s++) begin
      n = int'($urandom_range(1, 24));
      sess_q.delete();
      for (int k = 0; k < n; k++) sess_q.push_back(8'($urandom));
      run_session("random", 2, 1'($urandom), -1);
      model_apply(n, 1'b1);
      check_status("random");
      check_fetch("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_valid_toggle();
    test_overflow();
    test_fetch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
